instr_queue: RTL and testbench

Parametrised successor to the instruction register: a handshaked instruction queue that accepts opcode/operand triplets, computes each result in a one-stage execute pipeline, and buffers the completed instructions in a first-word-fall-through FIFO. It sits between the stimulus/test program (driving through `tb_ifc`) and any consumer of executed instructions. Unlike the flat addressed register, it adds backpressure, configurable depth and width, and in-block result computation.

---
 rtl/instr_register_pkg.sv | 18 +
 rtl/instr_queue_alu.sv | 49 ++++
 rtl/instr_queue.sv | 109 ++++++++++
 tb/tb_instr_queue.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/instr_register_pkg.sv
// Shared types for the instruction queue: opcode encodings used by the ALU,
// the queue top and any producer/consumer of executed instructions.
package instr_register_pkg;

  localparam int OPCODE_W = 3;

  typedef enum logic [OPCODE_W-1:0] {
    ZERO  = 3'd0,
    PASSA = 3'd1,
    PASSB = 3'd2,
    ADD   = 3'd3,
    SUB   = 3'd4,
    MULT  = 3'd5,
    DIV   = 3'd6,
    MOD   = 3'd7
  } opcode_t;

endpackage

// File: rtl/instr_queue_alu.sv
// Combinational execute unit: 2*OP_W-wide signed result and error flag.
// The divider exists only when INSTR_QUEUE_DIV_EN is defined.
module instr_queue_alu
  import instr_register_pkg::*;
#(
  parameter int OP_W = 32
) (
  input  opcode_t                  opcode,
  input  logic signed [OP_W-1:0]   operand_a,
  input  logic signed [OP_W-1:0]   operand_b,
  output logic signed [2*OP_W-1:0] result,
  output logic                     err
);

  logic signed [2*OP_W-1:0] a_x;
  logic signed [2*OP_W-1:0] b_x;

  assign a_x = {{OP_W{operand_a[OP_W-1]}}, operand_a};
  assign b_x = {{OP_W{operand_b[OP_W-1]}}, operand_b};

  always_comb begin
    result = '0;
    err    = 1'b0;
    case (opcode)
      ZERO:  result = '0;
      PASSA: result = a_x;
      PASSB: result = b_x;
      ADD:   result = a_x + b_x;
      SUB:   result = a_x - b_x;
      // Operands are sign-extended to full width, so the product cannot overflow.
      MULT:  result = a_x * b_x;
`ifdef INSTR_QUEUE_DIV_EN
      DIV: begin
        if (b_x == '0) err = 1'b1;
        else           result = a_x / b_x;
      end
      MOD: begin
        if (b_x == '0) err = 1'b1;
        else           result = a_x % b_x;
      end
`else
      DIV:   err = 1'b1;
      MOD:   err = 1'b1;
`endif
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/instr_queue.sv
// Handshaked instruction queue: one-stage execute pipeline feeding a FWFT FIFO.
// Division support is selected by INSTR_QUEUE_DIV_EN (inside instr_queue_alu).
module instr_queue
  import instr_register_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int OP_W  = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  opcode_t                       opcode,
  input  logic signed [OP_W-1:0]        operand_a,
  input  logic signed [OP_W-1:0]        operand_b,
  output logic                          out_valid,
  input  logic                          out_ready,
  output opcode_t                       out_opcode,
  output logic signed [OP_W-1:0]        out_operand_a,
  output logic signed [OP_W-1:0]        out_operand_b,
  output logic signed [2*OP_W-1:0]      out_result,
  output logic                          out_err,
  output logic [$clog2(DEPTH+1)-1:0]    count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  typedef struct packed {
    opcode_t               opcode;
    logic [OP_W-1:0]       a;
    logic [OP_W-1:0]       b;
    logic [2*OP_W-1:0]     result;
    logic                  err;
  } iq_entry_t;

  logic                     vld_p0;
  opcode_t                  opcode_p0;
  logic signed [OP_W-1:0]   a_p0;
  logic signed [OP_W-1:0]   b_p0;
  logic signed [2*OP_W-1:0] result_p0;
  logic                     err_p0;

  iq_entry_t                mem [DEPTH];
  iq_entry_t                head;
  logic [PW-1:0]            wr_ptr;
  logic [PW-1:0]            rd_ptr;
  logic [CW:0]              occupancy;
  logic                     accept;
  logic                     push;
  logic                     pop;

  // Occupancy counts the execute-stage slot so a commit always has room.
  assign occupancy = {1'b0, count} + {{CW{1'b0}}, vld_p0};
  assign in_ready  = occupancy < DEPTH_C;
  assign out_valid = (count != '0);
  assign accept    = in_valid && in_ready;
  assign push      = vld_p0;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p0 <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      vld_p0 <= accept;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Stage p0: execute-stage operand capture
  always_ff @(posedge clk) begin
    if (accept) begin
      opcode_p0 <= opcode;
      a_p0      <= operand_a;
      b_p0      <= operand_b;
    end
  end

  instr_queue_alu #(.OP_W(OP_W)) u_alu (
    .opcode    (opcode_p0),
    .operand_a (a_p0),
    .operand_b (b_p0),
    .result    (result_p0),
    .err       (err_p0)
  );

  // Stage p1: commit executed instruction into the FIFO
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {opcode_p0, a_p0, b_p0, result_p0, err_p0};
  end

  assign head          = mem[rd_ptr];
  assign out_opcode    = head.opcode;
  assign out_operand_a = head.a;
  assign out_operand_b = head.b;
  assign out_result    = head.result;
  assign out_err       = out_valid && head.err;

endmodule

// File: tb/tb_instr_queue.sv
// Scoreboard bench for instr_queue at DEPTH=4, OP_W=32.
module tb_instr_queue;
  import instr_register_pkg::*;

`ifdef INSTR_QUEUE_DIV_EN
  localparam bit DIV_ON = 1'b1;
`else
  localparam bit DIV_ON = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  opcode_t            opcode;
  logic signed [31:0] operand_a;
  logic signed [31:0] operand_b;
  logic               out_valid;
  logic               out_ready;
  opcode_t            out_opcode;
  logic signed [31:0] out_operand_a;
  logic signed [31:0] out_operand_b;
  logic signed [63:0] out_result;
  logic               out_err;
  logic [2:0]         count;

  instr_queue #(.DEPTH(4), .OP_W(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .opcode        (opcode),
    .operand_a     (operand_a),
    .operand_b     (operand_b),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_opcode    (out_opcode),
    .out_operand_a (out_operand_a),
    .out_operand_b (out_operand_b),
    .out_result    (out_result),
    .out_err       (out_err),
    .count         (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    opcode_t            op;
    logic signed [31:0] a;
    logic signed [31:0] b;
    logic signed [63:0] res;
    logic               err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Holds the triplet until accepted, then records the expected entry.
  task automatic push(input opcode_t op, input logic signed [31:0] a,
                      input logic signed [31:0] b, input logic signed [63:0] r,
                      input logic e);
    bit acc;
    int n;
    opcode    = op;
    operand_a = a;
    operand_b = b;
    in_valid  = 1'b1;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (acc) sb.push_back('{op, a, b, r, e});
    else begin
      total++;
      bad++;
      $display("FAIL push_timeout: got in_ready=0 expected 1 within 50 cycles");
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out: got result %0d expected no entry", out_result);
      end else begin
        mon_e = sb.pop_front();
        chk("out_opcode", out_opcode, mon_e.op);
        chk("out_operand_a", out_operand_a, mon_e.a);
        chk("out_operand_b", out_operand_b, mon_e.b);
        chk("out_result", out_result, mon_e.res);
        chk("out_err", out_err, mon_e.err);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    opcode = ZERO; operand_a = '0; operand_b = '0;
    cycles(2);
    chk("rst_count", count, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_err", out_err, 0);
    reset = 1'b0;
    cycles(1);

    // Single push with consumer stalled
    push(ADD, 5, 3, 8, 0);
    in_valid = 1'b0;
    chk("lat_out_valid_n", out_valid, 0);
    cycles(1);
    chk("lat_out_valid_n1", out_valid, 1);
    chk("lat_count", count, 1);
    chk("lat_result", out_result, 8);
    out_ready = 1'b1;
    cycles(3);

    // Opcode sweep a=-7 b=2
    push(ZERO,  -7, 2, 0, 0);
    push(PASSA, -7, 2, -7, 0);
    push(PASSB, -7, 2, 2, 0);
    push(ADD,   -7, 2, -5, 0);
    push(SUB,   -7, 2, -9, 0);
    push(MULT,  -7, 2, -14, 0);
    push(DIV,   -7, 2, DIV_ON ? -64'sd3 : 64'sd0, !DIV_ON);
    push(MOD,   -7, 2, DIV_ON ? -64'sd1 : 64'sd0, !DIV_ON);
    push(DIV,   10, 0, 0, 1);
    push(MOD,   10, 0, 0, 1);
    push(DIV,   10, 2, DIV_ON ? 64'sd5 : 64'sd0, !DIV_ON);
    in_valid = 1'b0;
    cycles(4);

    // Fill to capacity with consumer stalled
    out_ready = 1'b0;
    push(ADD, 1, 1, 2, 0);
    push(SUB, 9, 4, 5, 0);
    push(MULT, -3, -3, 9, 0);
    push(PASSB, 0, 77, 77, 0);
    chk("full_in_ready", in_ready, 0);
    opcode = ADD; operand_a = 100; operand_b = 100;
    cycles(3);
    chk("full_count", count, 4);
    chk("full_in_ready_hold", in_ready, 0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("pop_same_cycle_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("pop_next_in_ready", in_ready, 1);
    chk("pop_next_count", count, 3);
    out_ready = 1'b1;
    cycles(5);
    chk("drain_count", count, 0);

    // Streaming across pointer wrap
    for (int i = 0; i < 20; i++) begin
      push(ADD, i, 100, 64'(i + 100), 0);
      if (i >= 1) chk("stream_count", count, 1);
    end
    in_valid = 1'b0;
    cycles(4);
    chk("stream_drain_count", count, 0);

    // Asynchronous reset with 3 buffered and one executing
    out_ready = 1'b0;
    push(PASSA, 11, 0, 11, 0);
    push(PASSA, 12, 0, 12, 0);
    push(PASSA, 13, 0, 13, 0);
    push(PASSA, 14, 0, 14, 0);
    in_valid = 1'b0;
    chk("pre_rst_count", count, 3);
    #1;
    reset = 1'b1;
    sb.delete();
    #1;
    chk("async_rst_count", count, 0);
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_in_ready", in_ready, 1);
    chk("async_rst_out_err", out_err, 0);
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    cycles(3);
    chk("post_rst_out_valid", out_valid, 0);
    chk("post_rst_count", count, 0);

    chk("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
